// File: rtl/cache_writeback_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_writeback_if
// Purpose  : Eviction, memory-write and snoop signal bundle for the
//            cache write-back engine.
// Revision : 1.0 - initial release
// ============================================================================
interface cache_writeback_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int WORD_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 16
);
    // Eviction request from the cache controller
    logic                                 evict_valid;
    logic                                 evict_ready;
    logic [ADDR_WIDTH-1:0]                evict_addr;
    logic [WORD_WIDTH*WORDS_PER_LINE-1:0] evict_data;

    // Word-write channel to main memory
    logic                                 mem_wr_en;
    logic [ADDR_WIDTH-1:0]                mem_addr;
    logic [WORD_WIDTH-1:0]                mem_wdata;
    logic                                 mem_ack;

    // Status and snoop
    logic                                 busy;
    logic                                 done;
    logic [ADDR_WIDTH-1:0]                snoop_addr;
    logic                                 snoop_conflict;

    // Write-back engine side
    modport slave (
        input  evict_valid, evict_addr, evict_data, mem_ack, snoop_addr,
        output evict_ready, mem_wr_en, mem_addr, mem_wdata, busy, done,
               snoop_conflict
    );

    // Controller / memory side
    modport master (
        output evict_valid, evict_addr, evict_data, mem_ack, snoop_addr,
        input  evict_ready, mem_wr_en, mem_addr, mem_wdata, busy, done,
               snoop_conflict
    );
endinterface
`default_nettype wire

// File: rtl/cache_writeback.sv
`default_nettype none
// ============================================================================
// Module   : cache_writeback
// Purpose  : Buffers one evicted dirty cache line and serializes it to main
//            memory as sequential word writes under a valid/ack handshake.
//            Flags snoops that hit the line still being drained.
// Revision : 1.0 - initial release
// ============================================================================
module cache_writeback #(
    parameter int ADDR_WIDTH     = 32,
    parameter int WORD_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 16
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    cache_writeback_if.slave bus
);
    localparam int c_LINE_WIDTH = WORD_WIDTH * WORDS_PER_LINE;
    localparam int c_BEAT_W     = $clog2(WORDS_PER_LINE);
    localparam int c_BYTE_OFF   = $clog2(WORD_WIDTH / 8);
    localparam int c_LINE_OFF   = $clog2(c_LINE_WIDTH / 8);
    localparam int c_TAG_W      = ADDR_WIDTH - c_LINE_OFF;

    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(WORDS_PER_LINE - 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_SEND = 1'b1;

    logic [0:0]              r_state;
    logic [c_BEAT_W-1:0]     r_beat;
    logic [c_TAG_W-1:0]      r_line_tag;
    logic [c_LINE_WIDTH-1:0] r_line_data;
    logic                    r_done;

    logic                    w_send;
    logic                    w_last_ack;
    logic                    w_unused;

    assign w_send     = (r_state == c_SEND);
    assign w_last_ack = w_send && bus.mem_ack && (r_beat == c_LAST_BEAT);

    // Offset bits of incoming addresses carry no information for whole lines
    assign w_unused = &{1'b0, bus.evict_addr[c_LINE_OFF-1:0],
                        bus.snoop_addr[c_LINE_OFF-1:0]};

    // Ready is held low throughout reset so nothing is accepted while the
    // engine state is being cleared
    assign bus.evict_ready    = rst_n && (r_state == c_IDLE);
    assign bus.mem_wr_en      = w_send;
    assign bus.busy           = w_send;
    assign bus.done           = r_done;
    assign bus.mem_addr       = {r_line_tag, r_beat, c_BYTE_OFF'(0)};
    assign bus.mem_wdata      = r_line_data[r_beat*WORD_WIDTH +: WORD_WIDTH];
    assign bus.snoop_conflict = w_send &&
                                (bus.snoop_addr[ADDR_WIDTH-1:c_LINE_OFF] == r_line_tag);

    // Accept a line in IDLE, then step through its beats on each ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_beat      <= '0;
            r_line_tag  <= '0;
            r_line_data <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.evict_valid) begin
                        r_line_tag  <= bus.evict_addr[ADDR_WIDTH-1:c_LINE_OFF];
                        r_line_data <= bus.evict_data;
                        r_beat      <= '0;
                        r_state     <= c_SEND;
                    end
                end
                c_SEND: begin
                    if (bus.mem_ack) begin
                        // Beat counter holds at the last index; it is cleared on the next accept
                        if (r_beat == c_LAST_BEAT) begin
                            r_state <= c_IDLE;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // One-cycle completion pulse following the final acknowledged beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_last_ack;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_cache_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_writeback
// Purpose  : Directed self-checking bench for the cache write-back engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_writeback;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    cache_writeback_if #(.ADDR_WIDTH(32), .WORD_WIDTH(32), .WORDS_PER_LINE(16)) bus ();

    cache_writeback #(
        .ADDR_WIDTH    (32),
        .WORD_WIDTH    (32),
        .WORDS_PER_LINE(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] mk_line(input logic [31:0] base);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) begin
            l[32*i +: 32] = base + 32'(i);
        end
        return l;
    endfunction

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) begin
            l[32*i +: 32] = $urandom;
        end
        return l;
    endfunction

    // Called at the negedge where beat 0 is visible. Acks on every period-th
    // beat cycle; returns at the negedge where done is high.
    task automatic drain(input logic [31:0] line, input logic [31:0] wbase,
                         input int period, input int exp_lat);
        int beat;
        int k;
        bit finished;
        beat     = 0;
        k        = 0;
        finished = 0;
        for (int c = 0; c < 400 && !finished; c++) begin
            if (bus.done) begin
                check("done_latency", 64'(c), 64'(exp_lat));
                check("beats_sent", 64'(beat), 64'd16);
                check("done_busy", 64'(bus.busy), 64'd0);
                check("done_wr_en", 64'(bus.mem_wr_en), 64'd0);
                check("done_ready", 64'(bus.evict_ready), 64'd1);
                finished = 1;
            end else begin
                check("beat_wr_en", 64'(bus.mem_wr_en), 64'd1);
                check("beat_addr", 64'(bus.mem_addr), 64'(line + 32'(4 * beat)));
                check("beat_wdata", 64'(bus.mem_wdata), 64'(wbase + 32'(beat)));
                check("beat_busy", 64'(bus.busy), 64'd1);
                check("beat_ready", 64'(bus.evict_ready), 64'd0);
                if ((k % period) == period - 1) begin
                    bus.mem_ack = 1'b1;
                    beat++;
                end else begin
                    bus.mem_ack = 1'b0;
                end
                k++;
                @(negedge clk);
            end
        end
        if (!finished) check("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        rst_n           = 1'b0;
        bus.evict_valid = 1'b0;
        bus.evict_addr  = '0;
        bus.evict_data  = '0;
        bus.mem_ack     = 1'b0;
        bus.snoop_addr  = '0;

        // Reset with random inputs
        repeat (4) begin
            @(negedge clk);
            bus.evict_valid = 1'($urandom);
            bus.evict_addr  = $urandom;
            bus.evict_data  = rand_line();
            bus.mem_ack     = 1'($urandom);
            bus.snoop_addr  = 32'h0;
            #1;
            check("rst_wr_en", 64'(bus.mem_wr_en), 64'd0);
            check("rst_busy", 64'(bus.busy), 64'd0);
            check("rst_done", 64'(bus.done), 64'd0);
            check("rst_conflict", 64'(bus.snoop_conflict), 64'd0);
            check("rst_ready", 64'(bus.evict_ready), 64'd0);
        end
        @(negedge clk);
        bus.evict_valid = 1'b0;
        bus.mem_ack     = 1'b0;
        rst_n           = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(bus.evict_ready), 64'd1);
        check("post_rst_wr_en", 64'(bus.mem_wr_en), 64'd0);

        // Single line, zero-wait
        bus.evict_addr  = 32'h0000_1247;
        bus.evict_data  = mk_line(32'h1000_0000);
        bus.evict_valid = 1'b1;
        bus.mem_ack     = 1'b1;
        @(negedge clk);
        bus.evict_valid = 1'b0;
        drain(32'h0000_1240, 32'h1000_0000, 1, 16);
        @(negedge clk);
        check("zw_done_once", 64'(bus.done), 64'd0);

        // Same line with wait states, plus snoop checks during the drain
        bus.evict_valid = 1'b1;
        bus.mem_ack     = 1'b0;
        @(negedge clk);
        bus.evict_valid = 1'b0;
        bus.snoop_addr  = 32'h0000_127C;
        #1 check("snoop_hit", 64'(bus.snoop_conflict), 64'd1);
        bus.snoop_addr  = 32'h0000_1280;
        #1 check("snoop_next_line", 64'(bus.snoop_conflict), 64'd0);
        drain(32'h0000_1240, 32'h1000_0000, 4, 64);
        bus.snoop_addr  = 32'h0000_1240;
        #1 check("snoop_after_done", 64'(bus.snoop_conflict), 64'd0);
        @(negedge clk);
        check("ws_done_once", 64'(bus.done), 64'd0);

        // Back-to-back lines with evict_valid held high
        bus.mem_ack     = 1'b1;
        bus.evict_addr  = 32'h0000_1240;
        bus.evict_data  = mk_line(32'hA000_0000);
        bus.evict_valid = 1'b1;
        @(negedge clk);
        bus.evict_addr  = 32'h0000_8000;
        bus.evict_data  = mk_line(32'hB000_0000);
        drain(32'h0000_1240, 32'hA000_0000, 1, 16);
        @(negedge clk);
        bus.evict_valid = 1'b0;
        drain(32'h0000_8000, 32'hB000_0000, 1, 16);
        @(negedge clk);
        check("b2b_done_once", 64'(bus.done), 64'd0);

        // Reset in the middle of a line
        bus.evict_addr  = 32'h0000_1240;
        bus.evict_data  = mk_line(32'hC000_0000);
        bus.evict_valid = 1'b1;
        bus.mem_ack     = 1'b1;
        @(negedge clk);
        bus.evict_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("mid_addr", 64'(bus.mem_addr), 64'(32'h0000_1240 + 32'(4 * i)));
            @(negedge clk);
        end
        check("mid_beat6_addr", 64'(bus.mem_addr), 64'h0000_1258);
        bus.snoop_addr = 32'h0000_1240;
        rst_n          = 1'b0;
        #1;
        check("mid_rst_wr_en", 64'(bus.mem_wr_en), 64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_ready", 64'(bus.evict_ready), 64'd0);
        check("mid_rst_conflict", 64'(bus.snoop_conflict), 64'd0);
        bus.mem_ack = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("mid_rst_no_done", 64'(bus.done), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rel_no_done", 64'(bus.done), 64'd0);
        check("mid_rel_ready", 64'(bus.evict_ready), 64'd1);
        check("mid_rel_wr_en", 64'(bus.mem_wr_en), 64'd0);
        bus.evict_addr  = 32'h0000_2000;
        bus.evict_data  = mk_line(32'hD000_0000);
        bus.evict_valid = 1'b1;
        bus.mem_ack     = 1'b1;
        @(negedge clk);
        bus.evict_valid = 1'b0;
        drain(32'h0000_2000, 32'hD000_0000, 1, 16);
        @(negedge clk);
        check("mid_done_once", 64'(bus.done), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
